// File: rtl/loop_cntr_if.sv
// Command/status bundle for loop_cntr: load/step/clear requests in, count and run flags out.
interface loop_cntr_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] din;
  logic             ld;
  logic             dec;
  logic             inc;
  logic             clr;
  logic [WIDTH-1:0] dout;
  logic             eqz;
  logic             busy;
  logic             done;
  logic             tc;
  logic             uflow;

  modport master (
    output din, ld, dec, inc, clr,
    input  dout, eqz, busy, done, tc, uflow
  );

  modport slave (
    input  din, ld, dec, inc, clr,
    output dout, eqz, busy, done, tc, uflow
  );
endinterface

// File: rtl/loop_cntr.sv
// Loadable loop counter with IDLE/RUN/DONE sequencing and a one-shot terminal-count pulse.
// Optional sticky underflow detection is built only when LOOP_CNTR_UFLOW_EN is defined.
module loop_cntr #(
  parameter int WIDTH    = 16,
  parameter int MODE_SAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  loop_cntr_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (bus.clr) begin
      count_d = '0;
      state_d = IDLE;
    end else if (bus.ld) begin
      count_d = bus.din;
      state_d = (bus.din != '0) ? RUN : DONE;
    end else if (bus.inc && bus.dec) begin
      count_d = count_q;
    end else if (bus.inc) begin
      if (state_q == RUN) begin
        if (count_q == ALL_ONES) begin
          if (MODE_SAT == 0) begin
            count_d = '0;
            state_d = DONE;
          end
        end else begin
          count_d = count_q + ONE;
        end
      end
    end else if (bus.dec) begin
      // RUN never holds zero, so this decrement cannot wrap.
      if (state_q == RUN) begin
        count_d = count_q - ONE;
        if (count_q == ONE) state_d = DONE;
      end
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    tc_d   = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tc_q    <= tc_d;
    end
  end

`ifdef LOOP_CNTR_UFLOW_EN
  logic uflow_q, uflow_d;

  // A lone decrement at zero flags underflow; only clr, ld or reset clear it.
  always_comb begin
    uflow_d = uflow_q;
    if (bus.clr || bus.ld) begin
      uflow_d = 1'b0;
    end else if (bus.dec && !bus.inc && (count_q == '0)) begin
      uflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) uflow_q <= 1'b0;
    else        uflow_q <= uflow_d;
  end

  assign bus.uflow = uflow_q;
`else
  assign bus.uflow = 1'b0;
`endif

  assign bus.dout = count_q;
  assign bus.eqz  = (count_q == '0);
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.tc   = tc_q;

endmodule
